// File: rtl/alu_dvfs_sched.sv
// Round-robin sharing of one 32-bit ALU between NREQ requesters.
// Issue rate is throttled by the DVFS level, and the ALU is drained before a voltage/frequency change.
//   state    | meaning
//   ST_RUN   | normal issue, throttled by perf level
//   ST_DRAIN | issue blocked, waiting for in-flight op to complete
//   ST_HALT  | quiesced, dvfs_ack high, waiting for dvfs_req to drop
module alu_dvfs_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [63:0]       rsp_y,
    output logic              alu_en,
    output logic [1:0]        alu_op,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    input  logic [63:0]       alu_y,
    input  logic              alu_valid,
    input  logic              dvfs_req,
    input  logic [1:0]        dvfs_level,
    output logic              dvfs_ack,
    output logic [1:0]        perf_level,
    output logic              busy
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] inflight_id_q, inflight_id_d;
    logic [2:0]     slot_cnt_q, slot_cnt_d;
    logic           inflight_q, inflight_d;
    logic           dvfs_ack_q, dvfs_ack_d;
    logic [1:0]     perf_level_q, perf_level_d;

    logic [IDW-1:0] winner;
    logic           found;
    logic           issue;
    logic           complete;
    logic [2:0]     slot_reload;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    // rst_n gating keeps req_ready low for the whole reset assertion
    assign issue    = rst_n && (state_q == ST_RUN) && !dvfs_req &&
                      (slot_cnt_q == 3'd0) && found;
    assign complete = alu_valid && inflight_q;

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[winner] = 1'b1;
    end

    assign alu_en    = issue;
    assign alu_op    = req_op[2*int'(winner) +: 2];
    assign alu_a     = req_a[32*int'(winner) +: 32];
    assign alu_b     = req_b[32*int'(winner) +: 32];

    assign rsp_valid = complete;
    assign rsp_id    = inflight_id_q;
    assign rsp_y     = alu_y;

    assign dvfs_ack   = dvfs_ack_q;
    assign perf_level = perf_level_q;
    assign busy       = inflight_q;

    always_comb begin
        case (perf_level_q)
            2'd0:    slot_reload = 3'd0;
            2'd1:    slot_reload = 3'd1;
            2'd2:    slot_reload = 3'd3;
            default: slot_reload = 3'd7;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        inflight_d    = inflight_q;
        inflight_id_d = inflight_id_q;
        slot_cnt_d    = slot_cnt_q;
        perf_level_d  = perf_level_q;

        if (issue) begin
            inflight_d    = 1'b1;
            inflight_id_d = winner;
            rr_ptr_d      = (int'(winner) == NREQ-1) ? '0 : winner + 1'b1;
            slot_cnt_d    = slot_reload;
        end else begin
            if (complete) inflight_d = 1'b0;
            if (slot_cnt_q != 3'd0) slot_cnt_d = slot_cnt_q - 3'd1;
        end

        case (state_q)
            ST_RUN: begin
                if (dvfs_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // a withdrawn request wins over a finished drain: no ack, level kept
                if (!dvfs_req)        state_d = ST_RUN;
                else if (!inflight_q) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!dvfs_req) begin
                    state_d      = ST_RUN;
                    perf_level_d = dvfs_level;
                    slot_cnt_d   = 3'd0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        dvfs_ack_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
            slot_cnt_q    <= 3'd0;
            dvfs_ack_q    <= 1'b0;
            perf_level_q  <= 2'd0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            slot_cnt_q    <= slot_cnt_d;
            dvfs_ack_q    <= dvfs_ack_d;
            perf_level_q  <= perf_level_d;
        end
    end

endmodule

// File: tb/tb_alu_dvfs_sched.sv
// Directed bench for alu_dvfs_sched with a one-cycle-latency ALU model.
module tb_alu_dvfs_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_y;
    logic              alu_en;
    logic [1:0]        alu_op;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [63:0]       alu_y;
    logic              alu_valid;
    logic              dvfs_req;
    logic [1:0]        dvfs_level;
    logic              dvfs_ack;
    logic [1:0]        perf_level;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_dvfs_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_valid(alu_valid),
        .dvfs_req(dvfs_req), .dvfs_level(dvfs_level), .dvfs_ack(dvfs_ack),
        .perf_level(perf_level), .busy(busy)
    );

    // ALU reset is ~rst_n, i.e. it shares the scheduler's reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid <= 1'b0;
            alu_y     <= '0;
        end else begin
            alu_valid <= alu_en;
            case (alu_op)
                2'b00:   alu_y <= {32'b0, alu_a} + {32'b0, alu_b};
                2'b01:   alu_y <= {32'b0, alu_a - alu_b};
                default: alu_y <= {32'b0, alu_a} * {32'b0, alu_b};
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic go_halt(input logic [1:0] lvl);
        req_valid = '0;
        dvfs_req  = 1'b1;
        for (int n = 0; n < 10 && !dvfs_ack; n++) tick();
        chk("halt_ack", {63'b0, dvfs_ack}, 64'd1);
        dvfs_level = lvl;
        dvfs_req   = 1'b0;
        tick();
        chk("halt_exit_level", {62'b0, perf_level}, {62'b0, lvl});
        chk("halt_exit_ack", {63'b0, dvfs_ack}, 64'd0);
    endtask

    int          exp_g [5] = '{0, 1, 2, 3, 0};
    logic [63:0] exp_y [4];

    initial begin
        rst_n = 1'b0; req_valid = '1; req_op = '0; req_a = '0; req_b = '0;
        dvfs_req = 1'b0; dvfs_level = 2'd0;
        #12;
        chk("rst_ready", {60'b0, req_ready}, 64'd0);
        chk("rst_ack", {63'b0, dvfs_ack}, 64'd0);
        chk("rst_level", {62'b0, perf_level}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        req_valid = '0;
        #5 rst_n = 1'b1;
        tick();

        // 1: single add
        set_req(0, 2'b00, 32'd5, 32'd7);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", {60'b0, req_ready}, 64'b0001);
        chk("t1_alu_en", {63'b0, alu_en}, 64'd1);
        chk("t1_alu_a", {32'b0, alu_a}, 64'd5);
        tick();
        req_valid = '0;
        #1;
        chk("t1_rsp_valid", {63'b0, rsp_valid}, 64'd1);
        chk("t1_rsp_id", {62'b0, rsp_id}, 64'd0);
        chk("t1_rsp_y", rsp_y, 64'd12);
        chk("t1_busy", {63'b0, busy}, 64'd1);
        tick();
        chk("t1_rsp_gone", {63'b0, rsp_valid}, 64'd0);

        // 2: round robin from a fresh pointer
        rst_n = 1'b0; #3 rst_n = 1'b1;
        tick();
        set_req(0, 2'b00, 32'd1, 32'd1);
        set_req(1, 2'b01, 32'd10, 32'd3);
        set_req(2, 2'b10, 32'hFFFF_FFFF, 32'd2);
        set_req(3, 2'b00, 32'd100, 32'd1);
        exp_y[0] = 64'd2; exp_y[1] = 64'd7; exp_y[2] = 64'h1_FFFF_FFFE; exp_y[3] = 64'd101;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t2_grant", {60'b0, req_ready}, 64'd1 << exp_g[c]);
            if (c > 0) begin
                chk("t2_rsp_id", {62'b0, rsp_id}, 64'(exp_g[c-1]));
                chk("t2_rsp_y", rsp_y, exp_y[exp_g[c-1]]);
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("t2_last_valid", {63'b0, rsp_valid}, 64'd1);
        chk("t2_last_id", {62'b0, rsp_id}, 64'd0);
        tick();

        // 3: throttle at level 2 then 3
        go_halt(2'd2);
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("t3_lvl2_en", {63'b0, alu_en}, (i % 4 == 0) ? 64'd1 : 64'd0);
            tick();
        end
        go_halt(2'd3);
        req_valid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t3_lvl3_en", {63'b0, alu_en}, (i % 8 == 0) ? 64'd1 : 64'd0);
            tick();
        end
        go_halt(2'd0);

        // 4: quiesce right after an issue
        set_req(0, 2'b00, 32'd5, 32'd7);
        set_req(1, 2'b01, 32'd9, 32'd4);
        req_valid = 4'b0001;
        #1;
        chk("t4_issue", {63'b0, alu_en}, 64'd1);
        tick();
        dvfs_req = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("t4_ready_blocked", {60'b0, req_ready}, 64'd0);
        chk("t4_rsp_valid", {63'b0, rsp_valid}, 64'd1);
        chk("t4_rsp_y", rsp_y, 64'd12);
        tick();
        chk("t4_drain_ack", {63'b0, dvfs_ack}, 64'd0);
        chk("t4_drain_ready", {60'b0, req_ready}, 64'd0);
        tick();
        chk("t4_halt_ack", {63'b0, dvfs_ack}, 64'd1);
        tick();
        chk("t4_halt_ack_hold", {63'b0, dvfs_ack}, 64'd1);
        chk("t4_halt_ready", {60'b0, req_ready}, 64'd0);
        dvfs_req = 1'b0;
        dvfs_level = 2'd0;
        tick();
        chk("t4_resume_ready", {60'b0, req_ready}, 64'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("t4_resume_rsp_id", {62'b0, rsp_id}, 64'd1);
        chk("t4_resume_rsp_y", rsp_y, 64'd5);
        tick();

        // 5: reset with an op in flight
        go_halt(2'd3);
        set_req(2, 2'b00, 32'd1, 32'd2);
        req_valid = 4'b0100;
        #1;
        chk("t5_issue", {63'b0, alu_en}, 64'd1);
        tick();
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp", {63'b0, rsp_valid}, 64'd0);
        chk("t5_rst_busy", {63'b0, busy}, 64'd0);
        chk("t5_rst_ready", {60'b0, req_ready}, 64'd0);
        chk("t5_rst_level", {62'b0, perf_level}, 64'd0);
        chk("t5_rst_ack", {63'b0, dvfs_ack}, 64'd0);
        #3 rst_n = 1'b1;
        #1;
        chk("t5_rr_ptr0", {60'b0, req_ready}, 64'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t5_rsp_id", {62'b0, rsp_id}, 64'd0);
        chk("t5_rsp_y", rsp_y, 64'd12);
        tick();

        // 6: one-cycle dvfs_req pulse while idle at level 1
        go_halt(2'd1);
        req_valid = 4'b0001;
        dvfs_req = 1'b1;
        #1;
        chk("t6_pulse_ready", {60'b0, req_ready}, 64'd0);
        tick();
        dvfs_req = 1'b0;
        #1;
        chk("t6_drain_ready", {60'b0, req_ready}, 64'd0);
        chk("t6_drain_ack", {63'b0, dvfs_ack}, 64'd0);
        tick();
        chk("t6_run_ready", {60'b0, req_ready}, 64'b0001);
        chk("t6_run_ack", {63'b0, dvfs_ack}, 64'd0);
        chk("t6_level_kept", {62'b0, perf_level}, 64'd1);
        tick();
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
